// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Hazard detection for a 5-stage MIPS-style pipeline. The unit keeps its own
// record of the register producers in E and M, stalls the D instruction when
// a source operand cannot be forwarded in time, and tracks the multiply/divide
// unit (MDU). While the MDU is occupied, any further MDU instruction waits in D.
//
// Parameters
//   MULT_CYC    busy cycles of a multiply once it enters E
//   DIV_CYC     busy cycles of a divide once it enters E
//
// Ports
//   clk         clock, rising-edge active
//   reset_n     asynchronous active-low reset
//   A1_D/A2_D   rs / rt source register numbers of the D instruction
//   Tuse_rs_D   cycles until rs is needed (0..2, 3 = not used)
//   Tuse_rt_D   cycles until rt is needed (0..2, 3 = not used)
//   A3_D        destination register of the D instruction (0 = no write)
//   Tnew_D      cycles from E entry until the result can be forwarded
//   md_start_D  D instruction is mult/multu/div/divu
//   md_div_D    qualifies md_start_D as a divide
//   md_use_D    D instruction is mfhi/mflo/mthi/mtlo
//   stall       freeze PC and IF/ID
//   flush_E     insert a bubble into ID/EX (always equal to stall)
//   md_busy     MDU occupied
//   md_count    remaining MDU busy cycles
//   stall_cnt   (STALL_STATS_EN only) free-running count of stalled cycles
//
// Build option
//   STALL_STATS_EN  adds the stall_cnt output and its 32-bit wrapping counter.
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic [4:0]  A3_D,
  input  logic [1:0]  Tnew_D,
  input  logic        md_start_D,
  input  logic        md_div_D,
  input  logic        md_use_D,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic [3:0]  md_count
`ifdef STALL_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Shadow producer records for the E and M stages
  logic [4:0] a3_e_q,   a3_e_d;
  logic [1:0] tnew_e_q, tnew_e_d;
  logic [4:0] a3_m_q,   a3_m_d;
  logic [1:0] tnew_m_q, tnew_m_d;

  // MDU tracking
  logic       md_in_e_q,  md_in_e_d;
  logic       md_div_e_q, md_div_e_d;
  logic [3:0] md_count_q, md_count_d;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  // A source hazard exists when the nearest in-flight producer of the register
  // will not have its result ready by the time the operand is consumed. The
  // E-stage producer is younger than the M-stage one, so its match wins.
  function automatic logic src_hazard(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] a3_e,
    input logic [1:0] tnew_e,
    input logic [4:0] a3_m,
    input logic [1:0] tnew_m
  );
    logic hz;
    hz = 1'b0;
    if (addr != 5'd0 && tuse != TUSE_NONE) begin
      if (addr == a3_e) begin
        hz = (tnew_e > tuse);
      end else if (addr == a3_m) begin
        hz = (tnew_m > tuse);
      end
    end
    return hz;
  endfunction

  // ---------------------------------------------------------------------------
  // Stall decision (same cycle as its cause)
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_rs = src_hazard(A1_D, Tuse_rs_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall_rt = src_hazard(A2_D, Tuse_rt_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall_md = (md_use_D | md_start_D) & ((md_count_q != 4'd0) | md_in_e_q);
  end

  assign stall    = stall_rs | stall_rt | stall_md;
  assign flush_E  = stall;
  assign md_busy  = (md_count_q != 4'd0) | md_in_e_q;
  assign md_count = md_count_q;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // M takes whatever is in E, one cycle closer to being forwardable
    a3_m_d   = a3_e_q;
    tnew_m_d = (tnew_e_q != 2'd0) ? (tnew_e_q - 2'd1) : 2'd0;

    // A stalled D instruction does not advance; E receives a bubble instead
    if (stall) begin
      a3_e_d   = '0;
      tnew_e_d = '0;
    end else begin
      a3_e_d   = A3_D;
      tnew_e_d = Tnew_D;
    end

    md_in_e_d  = md_start_D & ~stall;
    md_div_e_d = md_start_D & md_div_D & ~stall;

    // Countdown is loaded in the cycle the MDU op sits in E, then runs to 0
    if (md_in_e_q) begin
      md_count_d = md_div_e_q ? DIV_LOAD : MULT_LOAD;
    end else if (md_count_q != 4'd0) begin
      md_count_d = md_count_q - 4'd1;
    end else begin
      md_count_d = md_count_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a3_e_q     <= '0;
      tnew_e_q   <= '0;
      a3_m_q     <= '0;
      tnew_m_q   <= '0;
      md_in_e_q  <= 1'b0;
      md_div_e_q <= 1'b0;
      md_count_q <= '0;
    end else begin
      a3_e_q     <= a3_e_d;
      tnew_e_q   <= tnew_e_d;
      a3_m_q     <= a3_m_d;
      tnew_m_q   <= tnew_m_d;
      md_in_e_q  <= md_in_e_d;
      md_div_e_q <= md_div_e_d;
      md_count_q <= md_count_d;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Wraps naturally from all-ones to zero
  always_comb begin
    stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Self-checking bench for hazard_stall_unit. The reference model keeps the
// history of instructions that left D (by cycle) and the issue cycle of the
// last MDU operation, and derives expected stall / MDU outputs from those.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset_n;
  logic [4:0]  A1_D, A2_D, A3_D;
  logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic        md_start_D, md_div_D, md_use_D;
  logic        stall, flush_E, md_busy;
  logic [3:0]  md_count;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  hazard_stall_unit #(
    .MULT_CYC(MULT_N),
    .DIV_CYC (DIV_N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .A1_D      (A1_D),
    .A2_D      (A2_D),
    .Tuse_rs_D (Tuse_rs_D),
    .Tuse_rt_D (Tuse_rt_D),
    .A3_D      (A3_D),
    .Tnew_D    (Tnew_D),
    .md_start_D(md_start_D),
    .md_div_D  (md_div_D),
    .md_use_D  (md_use_D),
    .stall     (stall),
    .flush_E   (flush_E),
    .md_busy   (md_busy),
    .md_count  (md_count)
`ifdef STALL_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] dst;
    int         tnew;
  } issued_t;

  issued_t     hist[$];   // instructions that left D, oldest first
  int          cyc;
  int          md_t;      // cycle in which the last MDU op left D
  int          md_len;
  logic [31:0] exp_cnt;

  function automatic void model_reset();
    issued_t b;
    b.dst  = '0;
    b.tnew = 0;
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    cyc     = 0;
    md_t    = -1000;
    md_len  = 0;
    exp_cnt = '0;
  endfunction

  // Producer issued one cycle ago is in E with its full Tnew; the one issued
  // two cycles ago is in M with one cycle of latency already spent.
  function automatic logic exp_src(input logic [4:0] a, input logic [1:0] tuse);
    issued_t e, m;
    int rem;
    if (a == 5'd0 || tuse == 2'd3) return 1'b0;
    e = hist[hist.size()-1];
    m = hist[hist.size()-2];
    if (e.dst == a) return (e.tnew > int'(tuse));
    if (m.dst == a) begin
      rem = (m.tnew > 0) ? m.tnew - 1 : 0;
      return (rem > int'(tuse));
    end
    return 1'b0;
  endfunction

  function automatic logic exp_busy();
    return (cyc >= md_t + 1) && (cyc <= md_t + md_len + 1);
  endfunction

  function automatic logic [3:0] exp_count();
    if (cyc >= md_t + 2 && cyc <= md_t + md_len + 1)
      return 4'(md_t + md_len + 2 - cyc);
    return 4'd0;
  endfunction

  // One D-stage cycle: drive, check against the model, advance the model.
  task automatic cyc_step(input logic [4:0] a1, input logic [4:0] a2,
                          input logic [1:0] tr, input logic [1:0] tt,
                          input logic [4:0] a3, input logic [1:0] tn,
                          input logic ms, input logic md, input logic mu,
                          output logic st);
    logic e_busy;
    logic [3:0] e_cnt;
    issued_t it;
    @(negedge clk);
    A1_D = a1; A2_D = a2; Tuse_rs_D = tr; Tuse_rt_D = tt;
    A3_D = a3; Tnew_D = tn; md_start_D = ms; md_div_D = md; md_use_D = mu;
    #2;
    e_busy = exp_busy();
    e_cnt  = exp_count();
    st = exp_src(a1, tr) | exp_src(a2, tt) | ((ms | mu) & e_busy);

    cmp_cnt++;
    if (stall !== st) begin
      err_cnt++;
      $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, st);
    end
    cmp_cnt++;
    if (flush_E !== st) begin
      err_cnt++;
      $display("FAIL flush_E cyc=%0d got=%b exp=%b", cyc, flush_E, st);
    end
    cmp_cnt++;
    if (md_busy !== e_busy) begin
      err_cnt++;
      $display("FAIL md_busy cyc=%0d got=%b exp=%b", cyc, md_busy, e_busy);
    end
    cmp_cnt++;
    if (md_count !== e_cnt) begin
      err_cnt++;
      $display("FAIL md_count cyc=%0d got=%0d exp=%0d", cyc, md_count, e_cnt);
    end
`ifdef STALL_STATS_EN
    cmp_cnt++;
    if (stall_cnt !== exp_cnt) begin
      err_cnt++;
      $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, exp_cnt);
    end
`endif

    if (st) begin
      it.dst  = '0;
      it.tnew = 0;
      exp_cnt = exp_cnt + 32'd1;
    end else begin
      it.dst  = a3;
      it.tnew = int'(tn);
      if (ms) begin
        md_t   = cyc;
        md_len = md ? DIV_N : MULT_N;
      end
    end
    hist.push_back(it);
    void'(hist.pop_front());
    cyc++;
  endtask

  // Present one instruction in D until it is accepted; returns stall cycles.
  task automatic issue(input logic [4:0] a1, input logic [4:0] a2,
                       input logic [1:0] tr, input logic [1:0] tt,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu,
                       output int nstall);
    logic st;
    nstall = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      cyc_step(a1, a2, tr, tt, a3, tn, ms, md, mu, st);
      if (!st) return;
      nstall++;
    end
    cmp_cnt++;
    err_cnt++;
    $display("FAIL issue_timeout got=%0d stall cycles exp=<40", nstall);
  endtask

  task automatic nop(input int unsigned n);
    int ns;
    for (int unsigned i = 0; i < n; i++)
      issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ns);
  endtask

  task automatic check_n(input string name, input int got, input int exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    A1_D = 5'd3; A2_D = 5'd3; Tuse_rs_D = 2'd0; Tuse_rt_D = 2'd0;
    A3_D = 5'd3; Tnew_D = 2'd2; md_start_D = 1'b1; md_div_D = 1'b1; md_use_D = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_n("reset_stall",    int'(stall),    0);
    check_n("reset_flush_E",  int'(flush_E),  0);
    check_n("reset_md_busy",  int'(md_busy),  0);
    check_n("reset_md_count", int'(md_count), 0);
`ifdef STALL_STATS_EN
    check_n("reset_stall_cnt", int'(stall_cnt), 0);
`endif
    A1_D = '0; A2_D = '0; Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3;
    A3_D = '0; Tnew_D = '0; md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_use();
    int ns;
    nop(2);
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0, ns);  // lw $3
    issue(5'd3, 5'd0, 2'd1, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0, ns);  // addu $5,$3
    check_n("load_use_stall_cycles", ns, 1);
    nop(2);
  endtask

  task automatic test_branch();
    int ns;
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0, ns);  // addu $4
    issue(5'd4, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ns);  // beq $4,$4
    check_n("branch_alu_stall_cycles", ns, 1);
    nop(2);
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0, ns);  // lw $4
    issue(5'd4, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ns);  // beq $4
    check_n("branch_load_stall_cycles", ns, 2);
    // Tnew equal to Tuse is covered by forwarding
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0, ns);  // addu $6
    issue(5'd0, 5'd6, 2'd3, 2'd1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0, ns);  // use $6 Tuse=1
    check_n("tnew_eq_tuse_stall_cycles", ns, 0);
    nop(2);
  endtask

  task automatic test_reg0();
    int ns;
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, ns);  // lw $0
    issue(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ns);  // use $0
    check_n("reg0_stall_cycles", ns, 0);
    nop(2);
  endtask

  task automatic test_div_mflo();
    int ns;
    logic st;
    int k;
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, ns);  // div
    k = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      cyc_step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1, st);  // mflo
      // first stalled cycle: div sits in E, countdown not yet loaded
      check_n("div_md_count_seq", int'(md_count), st ? ((k == 0) ? 0 : 11 - k) : 0);
      if (!st) break;
      k++;
    end
    check_n("div_mflo_stall_cycles", k, 11);
    nop(2);
  endtask

  task automatic test_back_to_back();
    int ns;
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, ns);  // mult
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, ns);  // mult
    check_n("b2b_mult_stall_cycles", ns, MULT_N + 1);
    nop(2);
    check_n("b2b_mult_reload", int'(md_count), MULT_N);
    nop(8);
  endtask

  task automatic test_reset_mid_div();
    int ns;
    logic st;
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, ns);  // div
    nop(5);
    cyc_step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, st);  // mflo waits
    check_n("mid_div_md_count", int'(md_count), 6);
    reset_n = 1'b0;
    #1;
    check_n("mid_div_rst_md_count", int'(md_count), 0);
    check_n("mid_div_rst_md_busy",  int'(md_busy),  0);
    check_n("mid_div_rst_stall",    int'(stall),    0);
    check_n("mid_div_rst_flush_E",  int'(flush_E),  0);
`ifdef STALL_STATS_EN
    check_n("mid_div_rst_stall_cnt", int'(stall_cnt), 0);
`endif
    model_reset();
    @(negedge clk);
    md_use_D = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    nop(1);
    check_n("post_rst_md_busy", int'(md_busy), 0);
  endtask

  task automatic test_random();
    logic st;
    logic [4:0] a1, a2, a3;
    logic [1:0] tr, tt, tn;
    logic ms, md, mu;
    for (int unsigned i = 0; i < 600; i++) begin
      a1 = 5'($urandom_range(0, 3));
      a2 = 5'($urandom_range(0, 3));
      a3 = 5'($urandom_range(0, 3));
      tr = 2'($urandom_range(0, 3));
      tt = 2'($urandom_range(0, 3));
      tn = 2'($urandom_range(0, 2));
      ms = ($urandom_range(0, 7) == 0);
      md = $urandom_range(0, 1) == 1;
      mu = ($urandom_range(0, 7) == 0);
      cyc_step(a1, a2, tr, tt, a3, tn, ms, md, mu, st);
    end
    nop(2);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch();
    test_reg0();
    test_div_mflo();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL expose parameter MULT_CYC, default 5, meaning the busy cycles of a multiply once it enters E.
REQ-002 SHALL expose parameter DIV_CYC, default 10, meaning the busy cycles of a divide once it enters E.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports A1_D and A2_D, input, 5 bits each: the rs and rt source registers read in D.
REQ-006 SHALL have ports Tuse_rs_D and Tuse_rt_D, input, 2 bits each: cycles until the operand is needed (0..2); 3 means not used.
REQ-007 SHALL have port A3_D, input, 5 bits: the destination register of the D instruction; 0 means no write.
REQ-008 SHALL have port Tnew_D, input, 2 bits: cycles from E entry until the result is forwardable.
REQ-009 SHALL have port md_start_D, input, 1 bit: the D instruction is mult/multu/div/divu.
REQ-010 SHALL have port md_div_D, input, 1 bit: qualifies md_start_D as a divide.
REQ-011 SHALL have port md_use_D, input, 1 bit: the D instruction is mfhi/mflo/mthi/mtlo.
REQ-012 SHALL have port stall, output, 1 bit: freeze the PC and the IF/ID register.
REQ-013 SHALL have port flush_E, output, 1 bit: load a bubble into ID/EX; always equal to stall.
REQ-014 SHALL have port md_busy, output, 1 bit: the MDU is occupied.
REQ-015 SHALL have port md_count, output, 4 bits: remaining MDU busy cycles.

Function
REQ-016 SHALL hold shadow stage registers A3_E/Tnew_E and A3_M/Tnew_M that track the producers in E and M.
REQ-017 SHALL update the shadow registers each cycle as follows: A3_M/Tnew_M take A3_E and max(Tnew_E-1,0); E takes A3_D/Tnew_D when stall=0, or A3=0/Tnew=0 when stall=1.
REQ-018 SHALL assert stall_rs when A1_D!=0, Tuse_rs_D!=3, and either (A1_D==A3_E and Tnew_E>Tuse_rs_D) or (A1_D==A3_M and Tnew_M>Tuse_rs_D); the E match takes precedence.
REQ-019 SHALL compute stall_rt identically from A2_D and Tuse_rt_D.
REQ-020 SHALL assert stall_md when (md_use_D or md_start_D) and (md_count!=0 or md_in_E).
REQ-021 SHALL drive stall as stall_rs | stall_rt | stall_md, combinationally, in the same cycle as its cause.
REQ-022 SHALL register md_in_E as md_start_D & ~stall, and md_div_E likewise.
REQ-023 SHALL load md_count with MULT_CYC or DIV_CYC on the cycle md_in_E=1; otherwise it decrements when nonzero and saturates at 0.
REQ-024 SHALL drive md_busy as (md_count!=0) | md_in_E.
REQ-025 SHALL never stall for a register 0 destination, nor when Tnew equals Tuse, because forwarding covers it.

Reset
REQ-026 SHALL, while reset_n=0, clear A3_E, Tnew_E, A3_M, Tnew_M, md_in_E, md_div_E and md_count to 0 immediately and asynchronously.
REQ-027 SHALL therefore, during reset, drive stall=0, flush_E=0, md_busy=0 and md_count=0.
REQ-028 SHALL abort an in-flight MDU countdown when reset asserts mid-operation, so that md_busy=0 on release.

Configuration
REQ-029 SHALL, when STALL_STATS_EN is defined, add output stall_cnt (32 bits): reset to 0, incremented on every cycle with stall=1, wrapping from 0xFFFFFFFF to 0.
REQ-030 SHALL, when STALL_STATS_EN is undefined, omit the port stall_cnt and its counter, with all other behaviour identical.

Verification
REQ-031 SHALL cover load-use: lw $3 (A3_D=3, Tnew_D=2), then addu reading $3 with Tuse_rs=1 -> stall=1 for exactly 1 cycle, then 0.
REQ-032 SHALL cover branch after ALU: addu $4 (Tnew_D=1), then beq reading $4 with Tuse=0 -> stall=1 for 1 cycle; with lw instead -> 2 cycles.
REQ-033 SHALL cover register 0: lw $0, then a use of $0 with Tuse=0 -> stall stays 0.
REQ-034 SHALL cover divide then mflo: div enters E, then md_use_D=1 -> md_count reads 10,9,...,1 and stall=1 for 11 cycles total; the mflo proceeds on the cycle md_count=0.
REQ-035 SHALL cover back-to-back mult: mult, then mult -> the second stalls until md_count=0, then reloads to 5.
REQ-036 SHALL cover reset mid-divide: assert reset_n=0 with md_count=6 -> md_count=0, md_busy=0 and stall=0 immediately; with STALL_STATS_EN defined, stall_cnt=0.
